// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: single-cycle MULT/MULTU, 32-step restoring DIV/DIVU,
// MTHI/MTLO moves, with pipeline stall, exception flush and HI/LO result registers.
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      r_state;
  logic [31:0] r_opa;     // multiplicand, or dividend shifting into quotient
  logic [31:0] r_opb;     // multiplier, or divisor magnitude
  logic [31:0] r_rem;
  logic        r_signed;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div_zero;
  logic [4:0]  r_cnt;

  logic        w_is_mul;
  logic        w_is_div;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [63:0] w_prod;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_a_abs  = (op == OP_DIV && A[31]) ? -A : A;
  assign w_b_abs  = (op == OP_DIV && B[31]) ? -B : B;

  // Sign-extending both operands to 64 bits makes the low 64 product bits correct for signed too.
  assign w_prod = {{32{r_signed & r_opa[31]}}, r_opa} * {{32{r_signed & r_opb[31]}}, r_opb};

  assign w_shift   = {r_rem, r_opa[31]};
  assign w_ge      = w_shift >= {1'b0, r_opb};
  assign w_sub     = w_shift[31:0] - r_opb;
  assign w_quo_fix = r_neg_q ? -r_opa : r_opa;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_MUL) || (r_state == S_FIX);
  assign stall = en && (w_is_mul || w_is_div) && !done && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      hi         <= '0;
      lo         <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_rem      <= '0;
      r_signed   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_cnt      <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            if (w_is_mul) begin
              r_opa    <= A;
              r_opb    <= B;
              r_signed <= (op == OP_MULT);
              r_state  <= S_MUL;
            end else if (w_is_div) begin
              r_opa      <= w_a_abs;
              r_opb      <= w_b_abs;
              r_rem      <= '0;
              r_neg_q    <= (op == OP_DIV) && (A[31] ^ B[31]);
              r_neg_r    <= (op == OP_DIV) && A[31];
              r_div_zero <= (B == 32'd0);
              r_cnt      <= '0;
              r_state    <= S_DIV;
            end else if (op == OP_MTHI) begin
              hi <= A;
            end else if (op == OP_MTLO) begin
              lo <= A;
            end
          end
        end
        S_MUL: begin
          hi      <= w_prod[63:32];
          lo      <= w_prod[31:0];
          r_state <= S_IDLE;
        end
        S_DIV: begin
          r_rem <= w_ge ? w_sub : w_shift[31:0];
          r_opa <= {r_opa[30:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          // A zero divisor still runs the full sequence but leaves HI/LO alone.
          if (!r_div_zero) begin
            lo <= w_quo_fix;
            hi <= w_rem_fix;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed corner cases plus randomized operation streams,
// compared against an arithmetic model of HI/LO and the expected stall/busy/done timing.
module tb_mdu_ctrl;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [63:0] exp_q[$];

  mdu_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .A(A), .B(B), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Architectural result of one operation, from plain integer arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint      sp, sq, sr;
    logic [63:0] up;
    case (o)
      OP_MULT:  begin sp = longint'($signed(a)) * longint'($signed(b)); h = sp[63:32]; l = sp[31:0]; end
      OP_MULTU: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
      OP_DIV: if (b != 32'd0) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        l = sq[31:0]; h = sr[31:0];
      end
      OP_DIVU: if (b != 32'd0) begin l = a / b; h = a % b; end
      OP_MTHI: h = a;
      OP_MTLO: l = a;
      default: ;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int flush_k, input bit chain);
    int          n;
    logic [31:0] nh, nl;
    logic [2:0]  exp_ctl;
    n = (o == OP_MULT || o == OP_MULTU) ? 1 : 33;
    @(negedge clk); en = 1'b1; op = o; A = a; B = b; flush = 1'b0;
    #2;
    vec_cnt++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      err_cnt++; $display("FAIL pre_hilo op=%0d: got %h_%h exp %h_%h", o, hi, lo, exp_hi, exp_lo);
    end
    vec_cnt++;
    if ({stall, busy, done} !== 3'b100) begin
      err_cnt++; $display("FAIL issue_ctl op=%0d: got sbd=%b exp 100", o, {stall, busy, done});
    end
    nh = exp_hi; nl = exp_lo;
    model(o, a, b, nh, nl);
    exp_q.push_back({nh, nl});
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == flush_k) flush = 1'b1;
      #2;
      exp_ctl = {(k != n) && (k != flush_k), 1'b1, k == n};
      vec_cnt++;
      if ({stall, busy, done} !== exp_ctl) begin
        err_cnt++; $display("FAIL cycle_ctl op=%0d k=%0d: got sbd=%b exp %b", o, k, {stall, busy, done}, exp_ctl);
      end
      if (k == flush_k) begin
        void'(exp_q.pop_front());
        @(negedge clk); flush = 1'b0; en = 1'b0;
        #2;
        vec_cnt++;
        if ({stall, busy, done, hi, lo} !== {3'b000, exp_hi, exp_lo}) begin
          err_cnt++; $display("FAIL flush_after op=%0d k=%0d: got sbd=%b %h_%h exp 000 %h_%h",
                              o, k, {stall, busy, done}, hi, lo, exp_hi, exp_lo);
        end
        return;
      end
    end
    {exp_hi, exp_lo} = exp_q.pop_front();
    if (!chain) begin
      @(negedge clk); en = 1'b0;
      #2;
      vec_cnt++;
      if ({stall, busy, done, hi, lo} !== {3'b000, exp_hi, exp_lo}) begin
        err_cnt++; $display("FAIL result op=%0d a=%h b=%h: got sbd=%b %h_%h exp 000 %h_%h",
                            o, a, b, {stall, busy, done}, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] a, input bit fl);
    @(negedge clk); en = 1'b1; op = o; A = a; B = $urandom; flush = fl;
    #2;
    vec_cnt++;
    if ({stall, busy, done} !== 3'b000) begin
      err_cnt++; $display("FAIL mt_ctl op=%0d: got sbd=%b exp 000", o, {stall, busy, done});
    end
    if (!fl) model(o, a, 32'd0, exp_hi, exp_lo);
    @(negedge clk); en = 1'b0; flush = 1'b0;
    #2;
    vec_cnt++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      err_cnt++; $display("FAIL mt_result op=%0d fl=%0d: got %h_%h exp %h_%h", o, fl, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; op = 3'b000; A = '0; B = '0;
    repeat (2) @(negedge clk);
    #2;
    vec_cnt++;
    if ({stall, busy, done, hi, lo} !== 67'd0) begin
      err_cnt++; $display("FAIL reset: got sbd=%b %h_%h exp all zero", {stall, busy, done}, hi, lo);
    end
    @(negedge clk); rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_rst_mid(input bit in_div);
    do_mt(OP_MTHI, 32'hA5A5_0001, 1'b0);
    do_mt(OP_MTLO, 32'h5A5A_0002, 1'b0);
    @(negedge clk); en = 1'b1; op = in_div ? OP_DIV : OP_MULT; A = 32'd1000; B = 32'd7;
    repeat (in_div ? 6 : 1) @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk); rst = 1'b0;
    #2;
    exp_hi = '0; exp_lo = '0;
    vec_cnt++;
    if ({stall, busy, done, hi, lo} !== 67'd0) begin
      err_cnt++; $display("FAIL rst_mid div=%0d: got sbd=%b %h_%h exp all zero", in_div, {stall, busy, done}, hi, lo);
    end
  endtask

  task automatic test_flush_issue();
    do_mt(OP_MTHI, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk); en = 1'b1; op = OP_DIV; A = 32'd99; B = 32'd3; flush = 1'b1;
    #2;
    vec_cnt++;
    if ({stall, busy, done} !== 3'b000) begin
      err_cnt++; $display("FAIL flush_issue_ctl: got sbd=%b exp 000", {stall, busy, done});
    end
    @(negedge clk); en = 1'b0; flush = 1'b0;
    #2;
    vec_cnt++;
    if ({stall, busy, done, hi, lo} !== {3'b000, exp_hi, exp_lo}) begin
      err_cnt++; $display("FAIL flush_issue_after: got sbd=%b %h_%h exp 000 %h_%h",
                          {stall, busy, done}, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_directed();
    do_op(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(OP_DIVU,  32'd7, 32'd2, 0, 1'b0);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(OP_DIVU,  32'h1234_5678, 32'd0, 0, 1'b0);
    do_op(OP_DIV,   32'd12345, 32'd17, 10, 1'b0);
    do_op(OP_DIV,   32'd12345, 32'd17, 33, 1'b0);
    do_op(OP_MULT,  32'h0001_0000, 32'h0001_0000, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_mt(OP_MTHI, 32'h1234_5678, 1'b0);
    do_op(OP_DIV,  32'hFFFF_FF00, 32'd5, 0, 1'b1);
    do_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b1);
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    int          fk;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: o = OP_MULT;
        1: o = OP_MULTU;
        2: o = OP_DIV;
        3: o = OP_DIVU;
        4: o = OP_MTHI;
        default: o = OP_MTLO;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      if (o == OP_MTHI || o == OP_MTLO) begin
        do_mt(o, a, $urandom_range(0, 7) == 0);
      end else begin
        fk = ($urandom_range(0, 7) == 0) ? $urandom_range(1, (o == OP_DIV || o == OP_DIVU) ? 33 : 1) : 0;
        do_op(o, a, b, fk, $urandom_range(0, 1) == 1);
      end
    end
    @(negedge clk); en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush_issue();
    test_rst_mid(1'b0);
    test_rst_mid(1'b1);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
